ins_fetch_unit: RTL and testbench
=================================

Name: ins_fetch_unit

Overview:
Instruction supplier for the pin-abstracted CPU; it is the other end of the 21-bit INS / CLK interface that benches currently drive by hand.
- Holds a loadable program memory and a program counter.
- Presents each instruction on INS, then issues one CPU step pulse on CPU_CLK.
- Advances the PC sequentially, or redirects it from the core's Addr output after a jump-type instruction.
- Stops on a HALT sentinel word.

Parameters:
AW, 8, program-memory address width; memory depth is 2**AW words
IW, 21, instruction width; must match the CPU INS bus
HALT_WORD, 21'h1FFFFF, sentinel instruction that stops the sequencer

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-high reset
LD_EN  in  1  program-load write strobe
LD_ADDR  in  AW  program-load write address
LD_DATA  in  IW  program-load write data
START  in  1  begin execution from address 0
CPU_ADDR  in  8  core Addr output (next address after a jump)
INS  out  IW  instruction presented to the CPU
CPU_CLK  out  1  CPU step clock
PC  out  AW  address of the instruction currently in INS
RUNNING  out  1  high in FETCH/SETUP/EXEC
HALTED  out  1  high in HALT
RETIRED  out  16  count of executed instructions

Behaviour:
- One clock domain, CLK. RST is asynchronous and active-high.
- Reset values:
  - state = IDLE; INS = 0; CPU_CLK = 0; PC = 0; RETIRED = 0.
  - RUNNING = 0; HALTED = 0.
  - Memory contents are not reset.
- Memory: 2**AW x IW. Synchronous write when LD_EN=1 and state is IDLE or HALT. Synchronous read, 1-cycle latency. LD_EN in any other state is ignored.
- FSM states:
  - IDLE: START=1 -> PC=0, RETIRED=0, go to FETCH.
  - FETCH: memory read at PC -> SETUP.
  - SETUP: INS <= read data; CPU_CLK=0.
    - If read data == HALT_WORD -> HALT; INS is still updated to the sentinel, and no CPU_CLK pulse is issued.
    - Otherwise -> EXEC.
  - EXEC: CPU_CLK=1 for exactly one CLK cycle. On exit, CPU_CLK=0 and RETIRED += 1, then -> FETCH.
    - If INS[20:19]==2'b00 (JMP type): PC <= CPU_ADDR[AW-1:0].
    - Otherwise: PC <= PC+1.
  - HALT: HALTED=1, INS holds the sentinel. START=1 -> PC=0, RETIRED=0, go to FETCH.
- Timing:
  - 3 CLK cycles per retired instruction.
  - INS is stable for at least 1 full cycle before the CPU_CLK rising edge and throughout the high phase.
  - INS changes only on the SETUP edge.
- Boundaries:
  - PC increment wraps from 2**AW-1 to 0.
  - CPU_ADDR is truncated to AW bits.
  - RETIRED wraps at 16'hFFFF -> 0.
  - START while RUNNING is ignored.
  - START and LD_EN in the same IDLE cycle: the write completes, and execution starts in the same cycle.
- RST mid-operation (including during EXEC with CPU_CLK=1): CPU_CLK drops immediately (asynchronously) and all outputs return to reset values.

Optional Feature:
Macro SINGLE_STEP_EN.
- Defined:
  - Adds input STEP (1 bit).
  - SETUP waits until STEP=1 before going to EXEC. HALT detection is unaffected.
  - A STEP held high advances at most one instruction per rising STEP edge, which is edge-detected internally.
- Undefined: no STEP port, and SETUP proceeds to EXEC unconditionally.

Test Plan:
- Load 0:{01,1,0111,000,000,0x0A}, 1:{01,1,0111,001,000,0x14}, 2:HALT_WORD; pulse START -> exactly 2 CPU_CLK pulses; RETIRED=2, HALTED=1, PC=2, INS=21'h1FFFFF.
- Check CPU_CLK spacing for the same program -> rising edges 3 CLK apart; INS constant from the SETUP edge through the end of EXEC.
- Word 0 = JMP type {00,0,0100,...} with bench CPU_ADDR=8'd5, word 5 = HALT_WORD -> PC sequence 0,5; halts with RETIRED=1.
- AW=2, words 0-3 non-JMP with no HALT; run 5 instructions -> PC sequence 0,1,2,3,0.
- Assert RST while CPU_CLK=1 -> CPU_CLK=0 before the next CLK edge; PC=0, RETIRED=0, INS=0. Memory is retained: START re-runs the program.
- LD_EN=1 while RUNNING targeting address 1 -> memory unchanged; program output is identical to the first scenario.
- SINGLE_STEP_EN defined: START with STEP held low -> 0 CPU_CLK pulses. Then 2 STEP pulses -> RETIRED=2.

Source files
------------

// File: rtl/ins_fetch_unit.sv
// Instruction sequencer: loadable program memory, PC and a one-pulse-per-instruction CPU step clock.
// Optional macro SINGLE_STEP_EN adds a STEP input that gates each instruction on a rising STEP edge.
module ins_fetch_unit #(
  parameter int              AW        = 8,
  parameter int              IW        = 21,
  parameter logic [IW-1:0]   HALT_WORD = 21'h1FFFFF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          LD_EN,
  input  logic [AW-1:0] LD_ADDR,
  input  logic [IW-1:0] LD_DATA,
  input  logic          START,
  input  logic [7:0]    CPU_ADDR,
`ifdef SINGLE_STEP_EN
  input  logic          STEP,
`endif
  output logic [IW-1:0] INS,
  output logic          CPU_CLK,
  output logic [AW-1:0] PC,
  output logic          RUNNING,
  output logic          HALTED,
  output logic [15:0]   RETIRED
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SETUP = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   mem [2**AW];
  logic [IW-1:0]   ins_q, ins_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [15:0]     retired_q, retired_d;
  logic            cpu_clk_q, cpu_clk_d;
  logic            wr_en;
  logic            start_ok;
  logic            step_ok;

  assign wr_en    = LD_EN && ((state_q == S_IDLE) || (state_q == S_HALT));
  assign start_ok = START && ((state_q == S_IDLE) || (state_q == S_HALT));

`ifdef SINGLE_STEP_EN
  // A STEP rise arms one instruction; the arm is consumed when SETUP hands over to EXEC.
  logic step_q;
  logic step_pend_q, step_pend_d;
  logic step_rise;
  logic step_take;

  assign step_rise = STEP && !step_q;
  assign step_take = (state_q == S_SETUP) && (state_d == S_EXEC);
  assign step_ok   = step_pend_q;

  always_comb begin
    step_pend_d = step_pend_q;
    if (step_take || start_ok) begin
      step_pend_d = 1'b0;
    end
    if (step_rise) begin
      step_pend_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      step_q      <= 1'b0;
      step_pend_q <= 1'b0;
    end else begin
      step_q      <= STEP;
      step_pend_q <= step_pend_d;
    end
  end
`else
  assign step_ok = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[LD_ADDR] <= LD_DATA;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start_ok) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_SETUP;
      S_SETUP: begin
        if (ins_q == HALT_WORD) begin
          state_d = S_HALT;
        end else if (step_ok) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC:  state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // INS is loaded on the edge into SETUP so it is stable a full cycle before CPU_CLK rises.
  always_comb begin
    pc_d      = pc_q;
    retired_d = retired_q;
    ins_d     = ins_q;
    cpu_clk_d = (state_d == S_EXEC);
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start_ok) begin
          pc_d      = '0;
          retired_d = '0;
        end
      end
      S_FETCH: ins_d = mem[pc_q];
      S_EXEC: begin
        retired_d = retired_q + 16'd1;
        if (ins_q[IW-1 -: 2] == 2'b00) begin
          pc_d = AW'(CPU_ADDR);
        end else begin
          pc_d = pc_q + AW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ins_q     <= '0;
      pc_q      <= '0;
      retired_q <= '0;
      cpu_clk_q <= 1'b0;
    end else begin
      ins_q     <= ins_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      cpu_clk_q <= cpu_clk_d;
    end
  end

  always_comb begin
    INS     = ins_q;
    PC      = pc_q;
    RETIRED = retired_q;
    CPU_CLK = cpu_clk_q;
    RUNNING = (state_q == S_FETCH) || (state_q == S_SETUP) || (state_q == S_EXEC);
    HALTED  = (state_q == S_HALT);
  end

endmodule

// File: tb/tb_ins_fetch_unit.sv
// Directed bench for ins_fetch_unit: table of small programs plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_ins_fetch_unit;

  localparam int          PER  = 10;
  localparam logic [20:0] HALT = 21'h1FFFFF;
  localparam logic [20:0] WA   = {2'b01, 1'b1, 4'b0111, 3'b000, 3'b000, 8'h0A};
  localparam logic [20:0] WB   = {2'b01, 1'b1, 4'b0111, 3'b001, 3'b000, 8'h14};
  localparam logic [20:0] WJ   = {2'b00, 1'b0, 4'b0100, 3'b000, 3'b000, 8'h00};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_en = 1'b0;
  logic [7:0]  ld_addr = '0;
  logic [20:0] ld_data = '0;
  logic        start = 1'b0;
  logic [7:0]  cpu_addr = '0;
  logic [20:0] ins;
  logic        cpu_clk;
  logic [7:0]  pc;
  logic        running;
  logic        halted;
  logic [15:0] retired;
`ifdef SINGLE_STEP_EN
  logic        step = 1'b0;
  logic        step2 = 1'b0;
`endif

  logic        rst2 = 1'b1;
  logic        ld_en2 = 1'b0;
  logic [1:0]  ld_addr2 = '0;
  logic [20:0] ld_data2 = '0;
  logic        start2 = 1'b0;
  logic [7:0]  cpu_addr2 = 8'hFF;
  logic [20:0] ins2;
  logic        cpu_clk2;
  logic [1:0]  pc2;
  logic        running2;
  logic        halted2;
  logic [15:0] retired2;

  always #(PER/2) clk = ~clk;

  ins_fetch_unit dut (
    .CLK(clk), .RST(rst), .LD_EN(ld_en), .LD_ADDR(ld_addr), .LD_DATA(ld_data),
    .START(start), .CPU_ADDR(cpu_addr),
`ifdef SINGLE_STEP_EN
    .STEP(step),
`endif
    .INS(ins), .CPU_CLK(cpu_clk), .PC(pc), .RUNNING(running), .HALTED(halted),
    .RETIRED(retired)
  );

  ins_fetch_unit #(.AW(2)) dut2 (
    .CLK(clk), .RST(rst2), .LD_EN(ld_en2), .LD_ADDR(ld_addr2), .LD_DATA(ld_data2),
    .START(start2), .CPU_ADDR(cpu_addr2),
`ifdef SINGLE_STEP_EN
    .STEP(step2),
`endif
    .INS(ins2), .CPU_CLK(cpu_clk2), .PC(pc2), .RUNNING(running2), .HALTED(halted2),
    .RETIRED(retired2)
  );

  // Observation of CPU_CLK edges and INS changes.
  time  t_ins_chg = 0;
  time  rise_t[$];
  logic [7:0] rise_pc[$];
  bit   rise_stable[$];
  bit   fall_ok[$];
  logic [1:0] rise_pc2[$];

  always @(ins) t_ins_chg = $time;

  always @(posedge cpu_clk) begin
    rise_stable.push_back(($time - t_ins_chg) >= PER);
    rise_t.push_back($time);
    rise_pc.push_back(pc);
  end

  always @(negedge cpu_clk) begin
    if (fall_ok.size() < rise_t.size())
      fall_ok.push_back(t_ins_chg < rise_t[rise_t.size()-1]);
  end

  always @(posedge cpu_clk2) rise_pc2.push_back(pc2);

  typedef struct packed {
    logic [3:0][7:0]  a;
    logic [3:0][20:0] d;
    logic [7:0]       cpu;
    logic [7:0]       np;
    logic [15:0]      ret;
    logic [7:0]       pc;
    logic [20:0]      ins;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [20:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    int n = 0;
    while (!halted && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_halted"}, {31'd0, halted}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  base;
    int  n;
    bit  ok;
    for (int i = 0; i < 4; i++) load(v.a[i], v.d[i]);
    cpu_addr = v.cpu;
    base = rise_t.size();
    pulse_start();
    wait_halt($sformatf("v%0d", idx));
    n = rise_t.size() - base;
    chk($sformatf("v%0d_pulses", idx), n, {24'd0, v.np});
    chk($sformatf("v%0d_retired", idx), {16'd0, retired}, {16'd0, v.ret});
    chk($sformatf("v%0d_pc", idx), {24'd0, pc}, {24'd0, v.pc});
    chk($sformatf("v%0d_ins", idx), {11'd0, ins}, {11'd0, v.ins});
    chk($sformatf("v%0d_running", idx), {31'd0, running}, 32'd0);
    if (n > 0) begin
      chk($sformatf("v%0d_first_pc", idx), {24'd0, rise_pc[base]}, 32'd0);
      ok = 1'b1;
      for (int i = 0; i < n; i++) begin
        if (!rise_stable[base+i] || !fall_ok[base+i]) ok = 1'b0;
      end
      chk($sformatf("v%0d_ins_stable", idx), {31'd0, ok}, 32'd1);
    end
    if (n > 1) begin
      ok = 1'b1;
      for (int i = 1; i < n; i++) begin
        if (rise_t[base+i] - rise_t[base+i-1] != 3*PER) ok = 1'b0;
      end
      chk($sformatf("v%0d_spacing", idx), {31'd0, ok}, 32'd1);
    end
  endtask

  vec_t vecs [6];
  int   exp_seq [5] = '{0, 1, 2, 3, 0};

  initial begin
    int base;
    int n;

    vecs[0] = '{{8'd0, 8'd1, 8'd2, 8'd2}, {WA, WB, HALT, HALT}, 8'd0, 8'd2, 16'd2, 8'd2, HALT};
    vecs[1] = '{{8'd0, 8'd5, 8'd5, 8'd5}, {WJ, HALT, HALT, HALT}, 8'd5, 8'd1, 16'd1, 8'd5, HALT};
    vecs[2] = '{{8'd0, 8'hFE, 8'hFF, 8'hFF}, {WJ, WB, HALT, HALT}, 8'hFE, 8'd2, 16'd2, 8'hFF, HALT};
    vecs[3] = '{{8'd0, 8'd1, 8'd2, 8'd3}, {WA, WA, WB, HALT}, 8'd0, 8'd3, 16'd3, 8'd3, HALT};
    vecs[4] = '{{8'd0, 8'd0, 8'd0, 8'd0}, {HALT, HALT, HALT, HALT}, 8'd0, 8'd0, 16'd0, 8'd0, HALT};
    vecs[5] = '{{8'd0, 8'd3, 8'd4, 8'd4}, {WJ, WA, HALT, HALT}, 8'd3, 8'd2, 16'd2, 8'd4, HALT};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    rst2 = 1'b0;
    @(negedge clk);
    chk("rst_ins", {11'd0, ins}, 32'd0);
    chk("rst_cpu_clk", {31'd0, cpu_clk}, 32'd0);
    chk("rst_pc", {24'd0, pc}, 32'd0);
    chk("rst_retired", {16'd0, retired}, 32'd0);
    chk("rst_running", {31'd0, running}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // PC wrap on a 4-word memory with no HALT word
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ld_en2 = 1'b1; ld_addr2 = i[1:0]; ld_data2 = (i % 2 == 1) ? WB : WA;
    end
    @(negedge clk);
    ld_en2 = 1'b0; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 0;
    while (rise_pc2.size() < 5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wrap_pulse_count", (rise_pc2.size() >= 5) ? 32'd1 : 32'd0, 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i < rise_pc2.size())
        chk($sformatf("wrap_pc%0d", i), {30'd0, rise_pc2[i]}, exp_seq[i]);
    end
    rst2 = 1'b1;

    // LD_EN and START while running are ignored
    load(8'd0, WA); load(8'd1, WB); load(8'd2, HALT);
    cpu_addr = 8'd0;
    base = rise_t.size();
    pulse_start();
    load(8'd1, HALT);
    n = 0;
    while (rise_t.size() <= base && n < 50) begin
      @(negedge clk);
      n++;
    end
    pulse_start();
    wait_halt("busy");
    chk("busy_pulses", rise_t.size() - base, 32'd2);
    chk("busy_retired", {16'd0, retired}, 32'd2);
    chk("busy_pc", {24'd0, pc}, 32'd2);

    // Asynchronous reset during the second instruction's CPU_CLK high phase
    base = rise_t.size();
    pulse_start();
    n = 0;
    while (!(rise_t.size() >= base + 2 && cpu_clk) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("exec_ins", {11'd0, ins}, {11'd0, WB});
    chk("exec_pc", {24'd0, pc}, 32'd1);
    chk("exec_retired", {16'd0, retired}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_cpu_clk", {31'd0, cpu_clk}, 32'd0);
    chk("mid_rst_pc", {24'd0, pc}, 32'd0);
    chk("mid_rst_retired", {16'd0, retired}, 32'd0);
    chk("mid_rst_ins", {11'd0, ins}, 32'd0);
    chk("mid_rst_running", {31'd0, running}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    base = rise_t.size();
    pulse_start();
    wait_halt("rerun");
    chk("rerun_pulses", rise_t.size() - base, 32'd2);
    chk("rerun_retired", {16'd0, retired}, 32'd2);

    // START together with a write in IDLE: the write lands before the first fetch
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 8'd0; ld_data = HALT; start = 1'b1;
    base = rise_t.size();
    @(negedge clk);
    ld_en = 1'b0; start = 1'b0;
    wait_halt("ldstart");
    chk("ldstart_pulses", rise_t.size() - base, 32'd0);
    chk("ldstart_retired", {16'd0, retired}, 32'd0);
    chk("ldstart_ins", {11'd0, ins}, {11'd0, HALT});

`ifdef SINGLE_STEP_EN
    load(8'd0, WA); load(8'd1, WB); load(8'd2, HALT);
    base = rise_t.size();
    pulse_start();
    repeat (20) @(negedge clk);
    chk("step_idle_pulses", rise_t.size() - base, 32'd0);
    chk("step_idle_running", {31'd0, running}, 32'd1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      step = 1'b1;
      repeat (4) @(negedge clk);
      step = 1'b0;
      repeat (6) @(negedge clk);
      chk($sformatf("step%0d_pulses", k), rise_t.size() - base, k + 1);
    end
    wait_halt("step");
    chk("step_retired", {16'd0, retired}, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
